// File: rtl/sgm_scan_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
package sgm_scan_pkg;

    // All segments off (active-low drive).
    localparam logic [7:0] SGM_OFF = 8'hFF;

    // Segment bit positions within the 8-bit segment word.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-low glyphs for hex digits 0..F, decimal point off.
    localparam logic [7:0] GLYPH [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/sgm_scan_hex_sgm.sv
// Combinational hex nibble to active-low a..g segment pattern.
module hex_sgm
    import sgm_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [7:0] glyph;

    // Table lookup; the dp bit of the table entry is dropped here.
    always_comb begin
        glyph = GLYPH[hex];
        seg   = glyph[SEG_G:SEG_A];
    end

endmodule

// File: rtl/sgm_scan.sv
// Time-multiplexed NDIG-digit common-anode 7-segment driver with per-slot
// blanking, frame-boundary snapshot and optional leading-zero blanking.
module sgm_scan
    import sgm_scan_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp_en,
    input  logic [NDIG-1:0]   dig_en,
    input  logic              lzb,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        sgm,
    output logic              frm
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] snap_data;
    logic [NDIG-1:0]   snap_dp;
    logic [NDIG-1:0]   snap_en;
    logic              snap_lzb;

    logic              slot_end;
    logic              frame_end;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_en;
    logic              cur_supp;
    logic              nz_seen;
    logic              lit;
    logic [6:0]        glyph;
    logic [NDIG-1:0]   an_next;
    logic [7:0]        sgm_next;

    assign slot_end  = (presc == PW'(DIV - 1));
    assign frame_end = slot_end && (idx == IW'(NDIG - 1));

    hex_sgm u_hex_sgm (
        .hex (cur_nib),
        .seg (glyph)
    );

    // Select the current digit's snapshot fields and decide whether it is lit.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_supp = 1'b0;
        nz_seen  = 1'b0;
        // Walk from the most significant digit down so nz_seen tells whether
        // any nibble at or above position i is non-zero.
        for (int i = NDIG - 1; i >= 0; i--) begin
            nz_seen = nz_seen | (|snap_data[4*i +: 4]);
            if (IW'(i) == idx) begin
                cur_nib  = snap_data[4*i +: 4];
                cur_dp   = snap_dp[i];
                cur_en   = snap_en[i];
                cur_supp = snap_lzb && (i != 0) && !nz_seen;
            end
        end
        lit      = (presc >= PW'(BLANK)) && cur_en && !cur_supp;
        an_next  = lit ? ~(NDIG'(1) << idx) : '1;
        sgm_next = lit ? {~cur_dp, glyph} : SGM_OFF;
    end

    // Prescaler, digit index, frame snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            presc     <= '0;
            idx       <= '0;
            snap_data <= '0;
            snap_dp   <= '0;
            snap_en   <= '0;
            snap_lzb  <= 1'b0;
            an        <= '1;
            sgm       <= SGM_OFF;
            frm       <= 1'b0;
        end else begin
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end) begin
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
            end
            if (frame_end) begin
                snap_data <= data;
                snap_dp   <= dp_en;
                snap_en   <= dig_en;
                snap_lzb  <= lzb;
            end
            an  <= an_next;
            sgm <= sgm_next;
            frm <= frame_end;
        end
    end

endmodule

// File: tb/tb_sgm_scan.sv
// Scoreboard bench for sgm_scan (NDIG=8, DIV=4, BLANK=1): a frame-level
// reference model predicts each cycle's outputs, a monitor compares them.
module tb_sgm_scan;

    localparam int NDIG  = 8;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = NDIG * DIV;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp_en;
    logic [7:0]  dig_en;
    logic        lzb;
    logic [7:0]  an;
    logic [7:0]  sgm;
    logic        frm;

    sgm_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .dp_en  (dp_en),
        .dig_en (dig_en),
        .lzb    (lzb),
        .an     (an),
        .sgm    (sgm),
        .frm    (frm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] sgm;
        logic       frm;
    } exp_t;

    exp_t q[$];
    int   gc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Independent glyph table for the model.
    logic [7:0] ref_glyph [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Model state: cycles since reset release, and the frame's shown word.
    int          mt = 0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_en = '0;
    logic        m_lzb = 1'b0;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, gc, act, req);
    endtask

    // Predict the outputs of the next cycle from the current model state and inputs.
    task automatic predict();
        exp_t e;
        int   digit;
        int   slot_pos;
        bit   supp;
        bit   lit;
        e.cyc = gc + 1;
        if (rst) begin
            e.an = 8'hFF; e.sgm = 8'hFF; e.frm = 1'b0;
            mt = 0; m_data = '0; m_dp = '0; m_en = '0; m_lzb = 1'b0;
        end else begin
            slot_pos = mt % DIV;
            digit    = (mt / DIV) % NDIG;
            supp     = m_lzb && digit > 0 && ((m_data >> (4 * digit)) == 0);
            lit      = slot_pos >= BLANK && m_en[digit] && !supp;
            if (lit) begin
                e.an  = ~(8'd1 << digit);
                e.sgm = ref_glyph[(m_data >> (4 * digit)) & 32'hF] & (m_dp[digit] ? 8'h7F : 8'hFF);
            end else begin
                e.an = 8'hFF; e.sgm = 8'hFF;
            end
            e.frm = (mt % FRAME) == FRAME - 1;
            if (e.frm) begin
                m_data = data; m_dp = dp_en; m_en = dig_en; m_lzb = lzb;
            end
            mt++;
        end
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            predict();
            @(posedge clk);
            #1;
            gc++;
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == gc) begin
            e = q.pop_front();
            check("outputs", {an, sgm, frm}, {e.an, e.sgm, e.frm});
            check("an_onehot", {16'h0, ($countones(~an) <= 1)}, 17'h1);
        end
    end

    initial begin
        rst = 1'b1; data = 32'h0; dp_en = 8'h0; dig_en = 8'h0; lzb = 1'b0;
        run(3);
        // Frame 0 shows the zero snapshot (dark); these inputs appear in frame 1.
        rst = 1'b0; data = 32'h000000A5; dig_en = 8'hFF; dp_en = 8'h00; lzb = 1'b1;
        run(40);
        // Mid-frame change must not disturb frame 1.
        data = 32'h00001234;
        run(FRAME + 24);
        // No leading-zero blanking, digit 2 disabled.
        data = 32'h000000A5; lzb = 1'b0; dig_en = 8'hFB;
        run(2 * FRAME);
        // Decimal point on digit 0.
        dp_en = 8'h01; dig_en = 8'hFF;
        run(2 * FRAME);
        // Reset mid-frame while digit 5 is being scanned.
        for (int k = 0; k < FRAME && ((mt / DIV) % NDIG) != 5; k++) run(1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2 * FRAME);
        // Randomised inputs with occasional resets.
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                data   = $urandom >> $urandom_range(0, 31);
                dp_en  = 8'($urandom);
                dig_en = 8'($urandom) | 8'($urandom);
                lzb    = 1'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            run(1);
        end
        rst = 1'b0;
        run(2);
        @(negedge clk);
        #1;
        check("drain", 17'(q.size()), 17'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
